// File: rtl/math_pkg.sv
// math_pkg: Booth digit type, FSM states and extended-width helper for mult_seq.
package math_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic two;
  } booth_t;

  function automatic int calc_nb(input int b_dw);
    return 2 * ((b_dw + 2) / 2);
  endfunction

  function automatic int calc_iter(input int b_dw);
    return calc_nb(b_dw) / 2;
  endfunction

  function automatic booth_t booth_dec(input logic [2:0] bits);
    booth_t d;
    d.neg  = bits[2];
    d.zero = (bits == 3'b000) || (bits == 3'b111);
    d.two  = (bits == 3'b011) || (bits == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/mbe_enc.sv
// mbe_enc: radix-4 Booth encoder; ones-complement partial product plus negate bit.
module mbe_enc
  import math_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   bits_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] pp_o,
  output logic         neg_o
);

  booth_t d;

  always_comb begin
    d     = booth_dec(bits_i);
    pp_o  = d.zero ? '0 : ((d.two ? {a_i[W-2:0], 1'b0} : a_i) ^ {W{d.neg}});
    neg_o = d.neg & ~d.zero;
  end

endmodule

// File: rtl/mult_seq.sv
// mult_seq: iterative radix-4 Booth multiplier; define MULT_SEQ_EARLY_EXIT_EN for early termination.
module mult_seq
  import math_pkg::*;
#(
  parameter int A_DW = 8,
  parameter int B_DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [A_DW-1:0]      a_i,
  input  logic [B_DW-1:0]      b_i,
  input  logic                 a_tc_i,
  input  logic                 b_tc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [A_DW+B_DW-1:0] c_o
);

  localparam int NB   = calc_nb(B_DW);
  localparam int ITER = calc_iter(B_DW);
  localparam int W    = A_DW + B_DW;
  localparam int CW   = $clog2(ITER + 1);

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, a_q, a_d, pp, a_ext;
  logic [NB:0]   b_q, b_d, b_sh;
  logic [NB-1:0] b_ext;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg, last;

  // Product is taken mod 2^W, so A only needs extending to W bits
  assign a_ext = {{B_DW{a_tc_i & a_i[A_DW-1]}}, a_i};
  assign b_ext = {{(NB-B_DW){b_tc_i & b_i[B_DW-1]}}, b_i};
  assign b_sh  = {{2{b_q[NB]}}, b_q[NB:2]};

  mbe_enc #(.W(W)) u_enc (
    .bits_i (b_q[2:0]),
    .a_i    (a_q),
    .pp_o   (pp),
    .neg_o  (neg)
  );

  always_comb begin
`ifdef MULT_SEQ_EARLY_EXIT_EN
    last = (cnt_q == CW'(ITER - 1)) || (&b_sh) || ~(|b_sh);
`else
    last = cnt_q == CW'(ITER - 1);
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        a_d     = a_ext;
        b_d     = {b_ext, 1'b0};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d   = acc_q + pp + {{(W-1){1'b0}}, neg};
        a_d     = {a_q[W-3:0], 2'b00};
        b_d     = b_sh;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : CALC;
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign c_o         = acc_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: randomized scoreboard bench for mult_seq with product and latency checks.
module tb_mult_seq;

  logic        clk = 0, rst = 1, in_valid_i = 0, a_tc_i = 0, b_tc_i = 0, out_ready_i = 0;
  logic        in_ready_o, out_valid_o;
  logic [7:0]  a_i = 0, b_i = 0;
  logic [15:0] c_o;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  bit          rnd_rdy = 0, prev_v = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  mult_seq #(.A_DW(8), .B_DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .a_tc_i      (a_tc_i),
    .b_tc_i      (b_tc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .c_o         (c_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] golden(input logic [7:0] a, b, input logic atc, btc);
    longint av, bv, p;
    av = atc ? longint'($signed(a)) : longint'(a);
    bv = btc ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[15:0];
  endfunction

  // Digits needed: stop once every multiplier bit from the next reference bit up is identical
  function automatic int exp_lat(input logic [7:0] b, input logic btc);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    logic [9:0] e;
    bit         same;
    e = {{2{btc & b[7]}}, b};
    for (int k = 1; k < 5; k++) begin
      same = 1;
      for (int j = 2 * k - 1; j < 10; j++) if (e[j] != e[9]) same = 0;
      if (same) return k;
    end
`endif
    return 5;
  endfunction

  // Monitor: samples at negedge; inputs are driven just after posedge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      acc_q.delete();
      prev_v = 0;
    end else begin
      if (out_valid_o && !prev_v) begin
        if (acc_q.size() == 0 || lat_q.size() == 0) check("spurious_valid", 1, 0);
        else check("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("product", c_o, exp_q.pop_front());
      end
      if (in_valid_i && in_ready_o) acc_q.push_back(cyc + 1);
      prev_v = out_valid_o;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, b, input logic atc, btc);
    int t = 0;
    a_i = a; b_i = b; a_tc_i = atc; b_tc_i = btc; in_valid_i = 1;
    while (!in_ready_o && t < 100) begin step(); t++; end
    if (!in_ready_o) begin
      check("accept_timeout", 0, 1);
      in_valid_i = 0;
      return;
    end
    exp_q.push_back(golden(a, b, atc, btc));
    lat_q.push_back(exp_lat(b, btc));
    step();
    in_valid_i = 0;
    a_i = 8'($urandom); b_i = 8'($urandom);
    a_tc_i = 1'($urandom); b_tc_i = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() > 0 || !in_ready_o) && t < 500) begin step(); t++; end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] held;
    int          t;
    step();
    step();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_c", c_o, 0);
    rst = 0;
    rnd_rdy = 1;

    send(8'h80, 8'h80, 1, 1);
    send(8'hFF, 8'hFF, 0, 0);
    send(8'hFF, 8'hFF, 1, 0);
    send(8'h7F, 8'h80, 1, 1);
    send(8'h80, 8'hFF, 0, 1);
    send(8'h00, 8'hFF, 1, 1);
    send(8'hFF, 8'h00, 1, 1);
    send(8'h55, 8'h55, 0, 0);
    send(8'h01, 8'hFF, 1, 1);
    for (int i = 0; i < 1500; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Result must wait in DONE while the consumer stalls
    rnd_rdy = 0;
    out_ready_i = 0;
    send(8'hA5, 8'h3C, 1, 0);
    t = 0;
    while (!out_valid_o && t < 20) begin step(); t++; end
    check("hold_valid_timeout", out_valid_o, 1);
    held = c_o;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", out_valid_o, 1);
      check("hold_c", c_o, held);
      check("hold_in_ready", in_ready_o, 0);
    end
    out_ready_i = 1;
    step();
    out_ready_i = 0;
    check("hold_release", out_valid_o, 0);
    check("hold_idle", in_ready_o, 1);

    // Reset in the third CALC cycle discards the operation
    a_i = 8'h37; b_i = 8'h59; a_tc_i = 0; b_tc_i = 0; in_valid_i = 1;
    step();
    in_valid_i = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check("abort_in_ready", in_ready_o, 1);
    check("abort_out_valid", out_valid_o, 0);
    check("abort_c", c_o, 0);
    out_ready_i = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_result", out_valid_o, 0);
    end

    rnd_rdy = 1;
    for (int i = 0; i < 50; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
